// File: rtl/pipe_stage_skid_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg: shared types for the pipeline stage registers.
//   stage_state_e : occupancy state of a pipeline stage (EMPTY/FULL/SKID)
//   OCC_W         : width of the occupancy count reported by a stage
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

    localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter: free-running event counter that sticks at its maximum value.
//   clk : clock
//   rst : asynchronous active-high clear
//   inc : count this cycle
//   cnt : current count, saturates at 2^W-1
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid: valid/ready pipeline stage register for one core boundary
// (IF/ID, ID/EX, EX/MEM, MEM/WB). The control bundle is forced to zero while
// the stage holds a bubble; the payload is simply held.
//
// With SKID=1 a second register absorbs the entry that arrives in the cycle
// downstream stalls, so in_ready can come from a flop and the backward stall
// path is cut. With SKID=0 the stage is a single register with combinational
// in_ready.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 kill every held entry and the one offered now
//   in_valid/in_ready     upstream handshake
//   in_ctrl/in_data       upstream control bundle / payload
//   out_valid/out_ready   downstream handshake
//   out_ctrl/out_data     registered control (0 on bubbles) / payload
//   occupancy             held entries, 0..2
//   stall_cnt             saturating count of out_valid & ~out_ready cycles
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 96,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    stage_state_e      state, state_nxt;
    logic              rdy_q;
    logic              accept, issue, stall_inc;
    logic              ld_main_in, ld_main_skid, ld_skid, clr_main, clr_skid;
    logic [CTRL_W-1:0] main_ctrl_p1, skid_ctrl_p1;
    logic [DATA_W-1:0] main_data_p1, skid_data_p1;

    // rdy_q is low through reset and for the first cycle after it, then
    // tracks "not in SKID". In SKID=0 builds it only provides that start-up
    // gap, since the state never reaches SKID.
    if (SKID != 0) begin : g_skid_ready
        assign in_ready = rdy_q;
    end else begin : g_comb_ready
        assign in_ready = rdy_q & (~out_valid | out_ready);
    end

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;
    assign stall_inc = out_valid & ~out_ready;
    assign out_ctrl  = main_ctrl_p1;
    assign out_data  = main_data_p1;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            EMPTY:   occupancy = 2'd0;
            FULL:    occupancy = 2'd1;
            default: occupancy = 2'd2;
        endcase
    end

    // Next-state and register load decisions. Flush overrides everything,
    // including an entry offered in the same cycle.
    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        clr_main     = 1'b0;
        clr_skid     = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
            clr_main  = 1'b1;
            clr_skid  = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt  = FULL;
                        ld_main_in = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && issue) begin
                        ld_main_in = 1'b1;
                    end else if (issue) begin
                        state_nxt = EMPTY;
                        clr_main  = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        // Main is stalled; park the newer entry behind it.
                        state_nxt = pipe_pkg::SKID;
                        ld_skid   = 1'b1;
                    end
                end
                pipe_pkg::SKID: begin
                    if (issue) begin
                        state_nxt    = FULL;
                        ld_main_skid = 1'b1;
                        clr_skid     = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    clr_main  = 1'b1;
                    clr_skid  = 1'b1;
                end
            endcase
        end
    end

    // Stage boundary: state and registered in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != pipe_pkg::SKID);
        end
    end

    // Stage boundary: main (output) and skid entry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl_p1 <= '0;
            main_data_p1 <= '0;
            skid_ctrl_p1 <= '0;
            skid_data_p1 <= '0;
        end else begin
            if (ld_main_in) begin
                main_ctrl_p1 <= in_ctrl;
                main_data_p1 <= in_data;
            end else if (ld_main_skid) begin
                main_ctrl_p1 <= skid_ctrl_p1;
                main_data_p1 <= skid_data_p1;
            end else if (clr_main) begin
                main_ctrl_p1 <= '0;
            end

            if (ld_skid) begin
                skid_ctrl_p1 <= in_ctrl;
                skid_data_p1 <= in_data;
            end else if (clr_skid) begin
                skid_ctrl_p1 <= '0;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid: two stages side by side, index 0 with the skid buffer
// (CNT_W=4 so saturation is reachable) and index 1 without it. A reference
// model holds each stage's contents as a plain FIFO of entries; accepted
// entries are pushed, a monitor pops and compares on every issue, and a
// per-cycle checker compares the visible state on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int CW = 8;
    localparam int DW = 32;
    localparam int EW = CW + DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          fl[2], iv[2], ordy[2];
    logic [CW-1:0] ic[2];
    logic [DW-1:0] id[2];

    logic          ir0, ir1, ov0, ov1;
    logic [CW-1:0] oc0, oc1;
    logic [DW-1:0] od0, od1;
    logic [1:0]    occ0, occ1;
    logic [3:0]    sc0;
    logic [15:0]   sc1;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir0), .in_ctrl(ic[0]), .in_data(id[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out_ctrl(oc0), .out_data(od0),
        .occupancy(occ0), .stall_cnt(sc0)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir1), .in_ctrl(ic[1]), .in_data(id[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .out_ctrl(oc1), .out_data(od1),
        .occupancy(occ1), .stall_cnt(sc1)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: FIFO contents, stall count, "out of reset one edge".
    logic [EW-1:0] mq[2][4];
    int            mn[2];
    int            ms[2];
    bit            live;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] dout(int d);
        return (d == 0) ? {oc0, od0} : {oc1, od1};
    endfunction

    function automatic logic [63:0] dsig(int d, int k);
        case (k)
            0:       return 64'((d == 0) ? ov0 : ov1);
            1:       return 64'((d == 0) ? ir0 : ir1);
            2:       return 64'((d == 0) ? occ0 : occ1);
            3:       return (d == 0) ? 64'(sc0) : 64'(sc1);
            default: return 64'((d == 0) ? oc0 : oc1);
        endcase
    endfunction

    function automatic bit exp_ready(int d);
        if (!live) return 1'b0;
        if (d == 0) return mn[0] < 2;
        return (mn[1] == 0) || ordy[1];
    endfunction

    function automatic int smax(int d);
        return (d == 0) ? 15 : 65535;
    endfunction

    // Model update and scoreboard pop/compare at each active edge.
    initial begin
        bit rdy;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    mn[d] = 0;
                    ms[d] = 0;
                end
                live = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    rdy = exp_ready(d);
                    if (mn[d] > 0 && !ordy[d])
                        ms[d] = (ms[d] >= smax(d)) ? smax(d) : ms[d] + 1;
                    if (fl[d]) begin
                        mn[d] = 0;
                    end else begin
                        if (mn[d] > 0 && ordy[d]) begin
                            chk("pop_entry", d, 64'(dout(d)), 64'(mq[d][0]));
                            for (int i = 0; i < 3; i++) mq[d][i] = mq[d][i+1];
                            mn[d]--;
                        end
                        if (iv[d] && rdy && mn[d] < 4) begin
                            mq[d][mn[d]] = {ic[d], id[d]};
                            mn[d]++;
                        end
                    end
                end
                live = 1'b1;
            end
        end
    end

    // Per-cycle checks on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int d = 0; d < 2; d++) begin
                    chk("out_valid", d, dsig(d, 0), 64'(mn[d] != 0));
                    chk("in_ready", d, dsig(d, 1), 64'(exp_ready(d)));
                    chk("occupancy", d, dsig(d, 2), 64'(mn[d]));
                    chk("stall_cnt", d, dsig(d, 3), 64'(ms[d]));
                    if (mn[d] != 0)
                        chk("head_hold", d, 64'(dout(d)), 64'(mq[d][0]));
                    else
                        chk("bubble_ctrl", d, dsig(d, 4), 64'(0));
                end
            end
        end
    end

    task automatic rnd(input int d, input int pv, input int pr, input int pf);
        iv[d]   = ($urandom_range(99) < pv);
        ordy[d] = ($urandom_range(99) < pr);
        fl[d]   = ($urandom_range(99) < pf);
        ic[d]   = CW'($urandom);
        id[d]   = $urandom;
    endtask

    task automatic set0(input bit v, input bit r, input bit f, input logic [CW-1:0] c, input logic [DW-1:0] dd);
        iv[0]   = v;
        ordy[0] = r;
        fl[0]   = f;
        ic[0]   = c;
        id[0]   = dd;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        rnd(1, 75, 50, 5);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; fl[d] = 1'b0; ic[d] = '0; id[d] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("ready_gap_after_rst", 0, 64'(ir0), 64'(0));
        step();
        chk("ready_after_rst", 0, 64'(ir0), 64'(1));

        // Streaming 1..10 with downstream always ready.
        for (int k = 1; k <= 10; k++) begin
            set0(1'b1, 1'b1, 1'b0, CW'(k), DW'(k));
            step();
        end

        // Back-pressure: 11 issues behind 10, 12 lands while stalled.
        set0(1'b1, 1'b1, 1'b0, 8'h0B, 32'd11);
        step();
        set0(1'b1, 1'b0, 1'b0, 8'h0C, 32'd12);
        step();
        set0(1'b1, 1'b0, 1'b0, 8'h0D, 32'd13);
        #1;
        chk("bp_occupancy", 0, 64'(occ0), 64'(2));
        chk("bp_in_ready", 0, 64'(ir0), 64'(0));
        chk("bp_head", 0, 64'(od0), 64'(11));
        step();
        set0(1'b0, 1'b1, 1'b0, 8'h00, 32'd0);
        repeat (3) step();

        // Randomised mix of traffic, back-pressure and flushes.
        repeat (300) begin
            rnd(0, 75, 60, 4);
            step();
        end

        // Flush with two entries held and 0x55 offered alongside.
        set0(1'b1, 1'b0, 1'b0, 8'h11, 32'h1111);
        repeat (3) step();
        set0(1'b1, 1'b0, 1'b1, 8'hAA, 32'h55);
        step();
        set0(1'b0, 1'b1, 1'b0, 8'h00, 32'd0);
        #1;
        chk("flush_valid", 0, 64'(ov0), 64'(0));
        chk("flush_ctrl", 0, 64'(oc0), 64'(0));
        chk("flush_occupancy", 0, 64'(occ0), 64'(0));
        repeat (3) step();

        // Stall counter saturation from a clean reset.
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        set0(1'b1, 1'b0, 1'b0, 8'h21, 32'h21);
        step();
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
        repeat (20) step();
        chk("stall_saturate", 0, 64'(sc0), 64'(15));
        step();
        chk("stall_hold", 0, 64'(sc0), 64'(15));

        // Asynchronous reset with two entries held.
        set0(1'b1, 1'b0, 1'b0, 8'h31, 32'h31);
        repeat (2) step();
        chk("pre_rst_occupancy", 0, 64'(occ0), 64'(2));
        rst = 1'b1;
        #1;
        chk("rst_valid", 0, 64'(ov0), 64'(0));
        chk("rst_occupancy", 0, 64'(occ0), 64'(0));
        chk("rst_stall_cnt", 0, 64'(sc0), 64'(0));
        chk("rst_ctrl", 0, 64'(oc0), 64'(0));
        chk("rst_valid", 1, 64'(ov1), 64'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("ready_gap_after_rst", 0, 64'(ir0), 64'(0));
        step();
        chk("ready_after_rst", 0, 64'(ir0), 64'(1));

        // Second randomised run, downstream toggling more often.
        repeat (300) begin
            rnd(0, 80, 40, 3);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
